// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with mul/div busy sequencing; decode latency 1 cycle, Busy for N cycles after a mul/div accept.
// in_ready drops while a mul/div is in flight; the source holds its op. No output backpressure.
module alu_control_seq #(
  parameter int ALUOP_W    = 4,
  parameter int FUNC_W     = 6,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 16
) (
  input  logic               CLK,
  input  logic               Reset_L,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] ALUop,
  input  logic [FUNC_W-1:0]  FuncCode,
  output logic               out_valid,
  output logic [CTRL_W-1:0]  ALUCtrl,
  output logic               Illegal,
  output logic               MulDivStart,
  output logic [1:0]         MulDivOp,
  output logic               Busy,
  output logic               MulDivDone
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  localparam logic [FUNC_W-1:0] FN_AND   = FUNC_W'(6'b100100);
  localparam logic [FUNC_W-1:0] FN_OR    = FUNC_W'(6'b100101);
  localparam logic [FUNC_W-1:0] FN_ADD   = FUNC_W'(6'b100000);
  localparam logic [FUNC_W-1:0] FN_SLL   = FUNC_W'(6'b000000);
  localparam logic [FUNC_W-1:0] FN_SRL   = FUNC_W'(6'b000010);
  localparam logic [FUNC_W-1:0] FN_SUB   = FUNC_W'(6'b100010);
  localparam logic [FUNC_W-1:0] FN_SLT   = FUNC_W'(6'b101010);
  localparam logic [FUNC_W-1:0] FN_ADDU  = FUNC_W'(6'b100001);
  localparam logic [FUNC_W-1:0] FN_SUBU  = FUNC_W'(6'b100011);
  localparam logic [FUNC_W-1:0] FN_XOR   = FUNC_W'(6'b100110);
  localparam logic [FUNC_W-1:0] FN_SLTU  = FUNC_W'(6'b101011);
  localparam logic [FUNC_W-1:0] FN_NOR   = FUNC_W'(6'b100111);
  localparam logic [FUNC_W-1:0] FN_SRA   = FUNC_W'(6'b000011);
  localparam logic [FUNC_W-1:0] FN_MULT  = FUNC_W'(6'b011000);
  localparam logic [FUNC_W-1:0] FN_MULTU = FUNC_W'(6'b011001);
  localparam logic [FUNC_W-1:0] FN_DIV   = FUNC_W'(6'b011010);
  localparam logic [FUNC_W-1:0] FN_DIVU  = FUNC_W'(6'b011011);

  localparam logic [CTRL_W-1:0] C_AND    = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] C_OR     = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] C_ADD    = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] C_SLL    = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] C_SRL    = CTRL_W'(4'b0100);
  localparam logic [CTRL_W-1:0] C_SUB    = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] C_SLT    = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] C_ADDU   = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] C_SUBU   = CTRL_W'(4'b1001);
  localparam logic [CTRL_W-1:0] C_XOR    = CTRL_W'(4'b1010);
  localparam logic [CTRL_W-1:0] C_SLTU   = CTRL_W'(4'b1011);
  localparam logic [CTRL_W-1:0] C_NOR    = CTRL_W'(4'b1100);
  localparam logic [CTRL_W-1:0] C_SRA    = CTRL_W'(4'b1101);
  localparam logic [CTRL_W-1:0] C_MULDIV = CTRL_W'(4'b1110);
  localparam logic [CTRL_W-1:0] C_ILL    = CTRL_W'(4'b1111);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_e;

  typedef struct packed {
    logic              vld;
    logic [CTRL_W-1:0] ctrl;
    logic              illegal;
    logic              start;
    logic [1:0]        op;
  } out_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  out_t              out_q, out_d;

  logic [CTRL_W-1:0] pass_ctrl;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;
  logic              dec_md;
  logic [1:0]        dec_op;
  logic              accept;

  // Non-R-type ops pass straight through, truncated or zero-extended to CTRL_W.
  if (ALUOP_W >= CTRL_W) begin : g_trunc
    assign pass_ctrl = ALUop[CTRL_W-1:0];
  end else begin : g_zext
    assign pass_ctrl = {{(CTRL_W-ALUOP_W){1'b0}}, ALUop};
  end

  always_comb begin
    dec_ctrl    = pass_ctrl;
    dec_illegal = 1'b0;
    dec_md      = 1'b0;
    dec_op      = 2'b00;
    if (&ALUop) begin
      case (FuncCode)
        FN_AND:   dec_ctrl = C_AND;
        FN_OR:    dec_ctrl = C_OR;
        FN_ADD:   dec_ctrl = C_ADD;
        FN_SLL:   dec_ctrl = C_SLL;
        FN_SRL:   dec_ctrl = C_SRL;
        FN_SUB:   dec_ctrl = C_SUB;
        FN_SLT:   dec_ctrl = C_SLT;
        FN_ADDU:  dec_ctrl = C_ADDU;
        FN_SUBU:  dec_ctrl = C_SUBU;
        FN_XOR:   dec_ctrl = C_XOR;
        FN_SLTU:  dec_ctrl = C_SLTU;
        FN_NOR:   dec_ctrl = C_NOR;
        FN_SRA:   dec_ctrl = C_SRA;
        FN_MULT:  begin dec_ctrl = C_MULDIV; dec_md = 1'b1; dec_op = 2'b00; end
        FN_MULTU: begin dec_ctrl = C_MULDIV; dec_md = 1'b1; dec_op = 2'b01; end
        FN_DIV:   begin dec_ctrl = C_MULDIV; dec_md = 1'b1; dec_op = 2'b10; end
        FN_DIVU:  begin dec_ctrl = C_MULDIV; dec_md = 1'b1; dec_op = 2'b11; end
        default:  begin dec_ctrl = C_ILL; dec_illegal = 1'b1; end
      endcase
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign accept     = in_valid && in_ready;
  assign Busy       = (state_q != ST_IDLE);
  assign MulDivDone = Busy && (cnt_q == '0);

  // Registered fields hold between accepts; only the strobes fall back to 0.
  // MulDivOp is refreshed only by mul/div accepts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    out_d.vld   = 1'b0;
    out_d.start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          out_d.vld     = 1'b1;
          out_d.ctrl    = dec_ctrl;
          out_d.illegal = dec_illegal;
          if (dec_md) begin
            out_d.start = 1'b1;
            out_d.op    = dec_op;
            state_d     = dec_op[1] ? ST_DIV : ST_MUL;
            cnt_d       = dec_op[1] ? DIV_LOAD : MUL_LOAD;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out_valid   = out_q.vld;
  assign ALUCtrl     = out_q.ctrl;
  assign Illegal     = out_q.illegal;
  assign MulDivStart = out_q.start;
  assign MulDivOp    = out_q.op;

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: default-parameter instance plus a MUL_CYCLES=1 instance.
module tb_alu_control_seq;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       Reset_L;
  logic       in_valid, in_valid1;
  logic [3:0] ALUop;
  logic [5:0] FuncCode;

  logic       in_ready, out_valid, Illegal, MulDivStart, Busy, MulDivDone;
  logic [3:0] ALUCtrl;
  logic [1:0] MulDivOp;

  logic       in_ready1, out_valid1, Illegal1, MulDivStart1, Busy1, MulDivDone1;
  logic [3:0] ALUCtrl1;
  logic [1:0] MulDivOp1;

  alu_control_seq dut (
    .CLK(CLK), .Reset_L(Reset_L), .in_valid(in_valid), .in_ready(in_ready),
    .ALUop(ALUop), .FuncCode(FuncCode), .out_valid(out_valid), .ALUCtrl(ALUCtrl),
    .Illegal(Illegal), .MulDivStart(MulDivStart), .MulDivOp(MulDivOp),
    .Busy(Busy), .MulDivDone(MulDivDone)
  );

  alu_control_seq #(.MUL_CYCLES(1), .DIV_CYCLES(2)) dut1 (
    .CLK(CLK), .Reset_L(Reset_L), .in_valid(in_valid1), .in_ready(in_ready1),
    .ALUop(ALUop), .FuncCode(FuncCode), .out_valid(out_valid1), .ALUCtrl(ALUCtrl1),
    .Illegal(Illegal1), .MulDivStart(MulDivStart1), .MulDivOp(MulDivOp1),
    .Busy(Busy1), .MulDivDone(MulDivDone1)
  );

  typedef struct {
    int         due;
    logic [3:0] ctrl;
    logic       ill;
    logic       md;
    logic [1:0] op;
  } exp_t;

  exp_t sb_q[$];

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   free_cyc = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  bit   chk_en = 1'b0;

  logic [3:0] m_ctrl;
  logic       m_ill;
  logic [1:0] m_op;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [5:0] fn);
    exp_t e;
    e.due = 0; e.ctrl = op; e.ill = 1'b0; e.md = 1'b0; e.op = 2'b00;
    if (op == 4'hF) begin
      case (fn)
        6'b100100: e.ctrl = 4'h0;
        6'b100101: e.ctrl = 4'h1;
        6'b100000: e.ctrl = 4'h2;
        6'b000000: e.ctrl = 4'h3;
        6'b000010: e.ctrl = 4'h4;
        6'b100010: e.ctrl = 4'h6;
        6'b101010: e.ctrl = 4'h7;
        6'b100001: e.ctrl = 4'h8;
        6'b100011: e.ctrl = 4'h9;
        6'b100110: e.ctrl = 4'hA;
        6'b101011: e.ctrl = 4'hB;
        6'b100111: e.ctrl = 4'hC;
        6'b000011: e.ctrl = 4'hD;
        6'b011000: begin e.ctrl = 4'hE; e.md = 1'b1; e.op = 2'b00; end
        6'b011001: begin e.ctrl = 4'hE; e.md = 1'b1; e.op = 2'b01; end
        6'b011010: begin e.ctrl = 4'hE; e.md = 1'b1; e.op = 2'b10; end
        6'b011011: begin e.ctrl = 4'hE; e.md = 1'b1; e.op = 2'b11; end
        default:   begin e.ctrl = 4'hF; e.ill = 1'b1; end
      endcase
    end
    return e;
  endfunction

  // Holds Reset_L low for n edges (with in_valid asserted) and resets the model after each.
  task automatic do_reset(input int n);
    Reset_L  = 1'b0;
    in_valid = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      #1;
      sb_q.delete();
      m_ctrl = 4'h0; m_ill = 1'b0; m_op = 2'b00;
      busy_lo = 1; busy_hi = 0;
      free_cyc = cyc + 1;
      chk_en = 1'b1;
    end
    Reset_L  = 1'b1;
    in_valid = 1'b0;
  endtask

  // Presents an op and holds it until the edge where the model says it is accepted.
  task automatic send(input logic [3:0] op, input logic [5:0] fn);
    exp_t e;
    int   acc;
    int   n;
    e = model(op, fn);
    ALUop    = op;
    FuncCode = fn;
    in_valid = 1'b1;
    acc = (free_cyc > cyc + 1) ? free_cyc : cyc + 1;
    repeat (acc - cyc) @(posedge CLK);
    #1;
    in_valid = 1'b0;
    e.due = acc;
    sb_q.push_back(e);
    if (e.md) begin
      n = e.op[1] ? 16 : 4;
      busy_lo  = acc;
      busy_hi  = acc + n - 1;
      free_cyc = acc + n + 1;
    end else begin
      free_cyc = acc + 1;
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  logic mon_v, mon_s, mon_busy;
  exp_t mon_e;
  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      mon_v = 1'b0;
      mon_s = 1'b0;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        mon_e  = sb_q.pop_front();
        mon_v  = 1'b1;
        mon_s  = mon_e.md;
        m_ctrl = mon_e.ctrl;
        m_ill  = mon_e.ill;
        if (mon_e.md) m_op = mon_e.op;
      end
      mon_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      check("out_valid",   32'(out_valid),   32'(mon_v));
      check("ALUCtrl",     32'(ALUCtrl),     32'(m_ctrl));
      check("Illegal",     32'(Illegal),     32'(m_ill));
      check("MulDivOp",    32'(MulDivOp),    32'(m_op));
      check("MulDivStart", 32'(MulDivStart), 32'(mon_s));
      check("Busy",        32'(Busy),        32'(mon_busy));
      check("in_ready",    32'(in_ready),    32'(!mon_busy));
      check("MulDivDone",  32'(MulDivDone),  32'(mon_busy && cyc == busy_hi));
    end
  end

  logic [5:0] rfn [15];

  initial begin
    rfn = '{6'b100100, 6'b100101, 6'b100000, 6'b000000, 6'b000010, 6'b100010,
            6'b101010, 6'b100001, 6'b100011, 6'b100110, 6'b101011, 6'b100111,
            6'b000011, 6'b111111, 6'b000001};
    Reset_L   = 1'b0;
    in_valid  = 1'b1;
    in_valid1 = 1'b0;
    ALUop     = 4'hF;
    FuncCode  = 6'b100000;

    do_reset(2);

    for (int i = 0; i < 15; i++) send(4'hF, rfn[i]);

    send(4'h2, 6'b111111);
    send(4'h6, 6'b000000);
    send(4'h0, 6'b011000);
    send(4'hE, 6'b101010);

    // MULT, then an ADD held during busy
    send(4'hF, 6'b011000);
    send(4'hF, 6'b100000);
    send(4'hF, 6'b011010);
    send(4'h3, 6'b000000);
    send(4'hF, 6'b011001);
    send(4'hF, 6'b100110);

    // DIVU interrupted by reset during its 7th busy cycle
    send(4'hF, 6'b011011);
    repeat (6) begin @(posedge CLK); #1; end
    do_reset(1);
    send(4'hF, 6'b100010);
    send(4'hF, 6'b011000);
    repeat (8) begin @(posedge CLK); #1; end

    // Single-cycle MULTU on the MUL_CYCLES=1 instance
    ALUop     = 4'hF;
    FuncCode  = 6'b011001;
    in_valid1 = 1'b1;
    @(posedge CLK);
    #1;
    in_valid1 = 1'b0;
    @(negedge CLK);
    check("n1_out_valid", 32'(out_valid1),   32'(1));
    check("n1_ALUCtrl",   32'(ALUCtrl1),     32'(4'hE));
    check("n1_MulDivOp",  32'(MulDivOp1),    32'(2'b01));
    check("n1_start",     32'(MulDivStart1), 32'(1));
    check("n1_busy",      32'(Busy1),        32'(1));
    check("n1_done",      32'(MulDivDone1),  32'(1));
    check("n1_in_ready",  32'(in_ready1),    32'(0));
    @(negedge CLK);
    check("n1_busy_end",  32'(Busy1),        32'(0));
    check("n1_done_end",  32'(MulDivDone1),  32'(0));
    check("n1_start_end", 32'(MulDivStart1), 32'(0));
    check("n1_ready_end", 32'(in_ready1),    32'(1));
    check("n1_op_hold",   32'(MulDivOp1),    32'(2'b01));
    @(posedge CLK);
    #1;
    send(4'h7, 6'b000000);
    repeat (3) begin @(posedge CLK); #1; end

    check("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
Parametrised, registered successor to the combinational ALU control decoder. It decodes ALUop/FuncCode into the 4-bit ALU control code through one pipeline register, with a valid/ready handshake. It adds multi-cycle multiply/divide sequencing: a busy state machine that counts down the operation latency, stalls the issue stage, and pulses a done strobe. It sits between the main control unit and the ALU / mul-div unit.

Parameters:
ALUOP_W, 4, width of ALUop; the all-ones value marks an R-type instruction.
FUNC_W, 6, width of FuncCode.
CTRL_W, 4, width of ALUCtrl.
MUL_CYCLES, 4, busy cycles for MULT/MULTU; must be 1 or more.
DIV_CYCLES, 16, busy cycles for DIV/DIVU; must be 1 or more.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
Reset_L  in  1  synchronous reset, active-low.
in_valid  in  1  ALUop/FuncCode valid this cycle.
in_ready  out  1  block can accept; equals NOT Busy.
ALUop  in  ALUOP_W  op class from main control.
FuncCode  in  FUNC_W  R-type function field.
out_valid  out  1  ALUCtrl/Illegal valid; single-cycle pulse.
ALUCtrl  out  CTRL_W  registered ALU control code.
Illegal  out  1  registered; unknown R-type FuncCode.
MulDivStart  out  1  one-cycle pulse when a mul/div is accepted.
MulDivOp  out  2  registered op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
Busy  out  1  mul/div in progress; the issue stage stalls on this.
MulDivDone  out  1  one-cycle pulse in the last busy cycle.

Behaviour:
- Interface: one clock CLK; Reset_L is synchronous and active-low.
- Reset (Reset_L=0 at an edge):
  - All outputs go to 0 (ALUCtrl=0, MulDivOp=00).
  - State goes to IDLE and the counter goes to 0.
  - Reset overrides every other event, including mid mul/div; no MulDivDone is emitted.
- Accept: an op is accepted when in_valid && in_ready at an edge.
  - out_valid=1 in the following cycle (latency 1).
  - out_valid is 0 in every cycle without an accept.
  - No output backpressure.
- Decode when ALUop is all-ones (R-type), FuncCode to ALUCtrl:
  - 100100 gives 0000 (AND); 100101 gives 0001 (OR); 100000 gives 0010 (ADD).
  - 000000 gives 0011 (SLL); 000010 gives 0100 (SRL); 100010 gives 0110 (SUB).
  - 101010 gives 0111 (SLT); 100001 gives 1000 (ADDU); 100011 gives 1001 (SUBU).
  - 100110 gives 1010 (XOR); 101011 gives 1011 (SLTU); 100111 gives 1100 (NOR).
  - 000011 gives 1101 (SRA).
  - 011000/011001/011010/011011 give 1110 (MULDIV) and MulDivOp 00/01/10/11.
  - Any other FuncCode gives 1111 and Illegal=1. Illegal is 0 otherwise.
- Decode when ALUop is not all-ones: ALUCtrl = ALUop.
  - ALUOP_W > CTRL_W: take the low CTRL_W bits.
  - ALUOP_W < CTRL_W: zero-extend.
  - Illegal=0.
- Outputs hold their last value between accepts; only the strobes return to 0.
- State machine IDLE, MUL, DIV:
  - IDLE, accept of MULT/MULTU: go to MUL, cnt = MUL_CYCLES-1.
  - IDLE, accept of DIV/DIVU: go to DIV, cnt = DIV_CYCLES-1.
  - MulDivStart=1 in the cycle after the accept, together with out_valid.
  - MUL/DIV: Busy=1 and in_ready=0 in every cycle spent in MUL/DIV.
  - MUL/DIV, cnt==0: MulDivDone=1 in that cycle, then return to IDLE.
  - MUL/DIV, cnt!=0: cnt decrements by 1.
  - Busy runs for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES), starting in the cycle after the accept.
  - With N=1, Busy, MulDivStart and MulDivDone are all high in the same single cycle.
- in_valid while Busy: not accepted and no output change; the source must hold the op until in_ready=1.
- Back-to-back accepts in consecutive IDLE cycles are allowed for non-mul/div ops.
- The first cycle after MulDivDone is IDLE, so in_ready=1 and a new op can be accepted.
- Counter width: clog2(max(MUL_CYCLES,DIV_CYCLES)) bits, minimum 1.

Test Plan:
- Reset: hold Reset_L=0 for 2 cycles with in_valid=1 -> all outputs 0, in_ready=1; first accept after release -> out_valid one cycle later.
- R-type sweep: ALUop=1111 with each of the 13 FuncCodes -> ALUCtrl per table, 1 cycle later. FuncCode=111111 -> ALUCtrl=1111, Illegal=1.
- Pass-through: ALUop=0010 then 0110 on consecutive cycles -> ALUCtrl=0010 then 0110 on consecutive out_valid cycles, Illegal=0.
- MULT: FuncCode=011000 with MUL_CYCLES=4 -> MulDivStart/out_valid at t+1, ALUCtrl=1110, MulDivOp=00. Busy at t+1..t+4, MulDivDone at t+4, in_ready=1 at t+5. in_valid held during busy -> accepted only at t+5.
- DIVU with DIV_CYCLES=16: Reset_L=0 on busy cycle 7 -> Busy=0, MulDivDone never pulses, next accept behaves normally.
- Edge latency MUL_CYCLES=1: MULTU -> Busy, MulDivStart and MulDivDone all high in the same single cycle, MulDivOp=01.
